// File: rtl/axis_fifo_pkg.sv
// Shared types and helpers for the AXI-Stream packet FIFO.
// The escape FSM state type and the pointer-width helper live here.
package axis_fifo_pkg;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_ESCAPE = 1'b1
    } esc_state_t;

    // Pointer width: address bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module axis_fifo_ram #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI-Stream FIFO with TLAST, occupancy flags and optional store-and-forward.
// The escape FSM releases an oversized packet as cut-through so the FIFO cannot deadlock.
module axis_pkt_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 9,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned PACKET_MODE = 0,
    parameter int unsigned AF_THRESH   = 12,
    parameter int unsigned AE_THRESH   = 2
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic [DATA_WIDTH-1:0]        data_i,
    input  logic                         last_i,
    input  logic                         valid_i,
    output logic                         ready_i,
    output logic [DATA_WIDTH-1:0]        data_o,
    output logic                         last_o,
    output logic                         valid_o,
    input  logic                         ready_o,
    output logic [$clog2(FIFO_DEPTH):0]  count_o,
    output logic [$clog2(FIFO_DEPTH):0]  pkt_count_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic                         oversize_o
);

    localparam int unsigned   PW        = ptr_width(FIFO_DEPTH);
    localparam int unsigned   AW        = PW - 1;
    localparam logic [PW-1:0] DEPTH_CNT = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] AF_CNT    = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_CNT    = PW'(AE_THRESH);

    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [PW-1:0]   count;
    esc_state_t      state_q, state_d;
    logic            oversize_q, oversize_d;
    logic            full, wr, rd, wr_last, rd_last, head_ok;
    logic [DATA_WIDTH:0] rd_word;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign full    = (count == DEPTH_CNT);
    assign ready_i = ~full & ~areset;

    // In packet mode the head is held back until a whole packet (or an escape) is present.
    assign head_ok = (PACKET_MODE == 0) || (pkt_cnt_q != '0) || (state_q == ST_ESCAPE);
    assign valid_o = (count != '0) & head_ok & ~areset;

    assign wr      = valid_i & ready_i;
    assign rd      = valid_o & ready_o;
    assign wr_last = wr & last_i;
    assign rd_last = rd & last_o;

    assign {last_o, data_o} = rd_word;
    assign count_o          = count;
    assign pkt_count_o      = pkt_cnt_q;
    assign almost_full_o    = (count >= AF_CNT);
    assign almost_empty_o   = (count <= AE_CNT);
    assign oversize_o       = oversize_q;

    axis_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_ram (
        .clk   (aclk),
        .we    (wr),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata ({last_i, data_i}),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rd_word)
    );

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        case ({wr_last, rd_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= ST_NORMAL;
            oversize_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            oversize_q <= oversize_d;
        end
    end

    // Full with no complete packet means the packet can never fit: escape to cut-through.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_NORMAL: begin
                if ((PACKET_MODE != 0) && full && (pkt_cnt_q == '0)) begin
                    state_d = ST_ESCAPE;
                end
            end
            ST_ESCAPE: begin
                if (rd_last) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    always_comb begin
        oversize_d = oversize_q | ((state_q == ST_NORMAL) && (state_d == ST_ESCAPE));
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: one cut-through instance and one store-and-forward instance.
module tb_axis_pkt_fifo;

    logic       aclk;
    logic       areset;

    logic [8:0] d0_data, d1_data;
    logic       d0_last, d1_last;
    logic       d0_valid, d1_valid;
    logic       d0_rdy, d1_rdy;

    logic       r0_ready, r1_ready;
    logic [8:0] q0_data, q1_data;
    logic       q0_last, q1_last;
    logic       q0_valid, q1_valid;
    logic [4:0] c0_count, c1_count;
    logic [4:0] c0_pkt, c1_pkt;
    logic       f0_af, f1_af, f0_ae, f1_ae;
    logic       o0_over, o1_over;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0]  mq [$];
    logic [19:0] last_pat;
    int          wr_idx, rd_idx;
    logic        do_rd, do_wr;

    axis_pkt_fifo #(
        .DATA_WIDTH  (9),
        .FIFO_DEPTH  (16),
        .PACKET_MODE (0),
        .AF_THRESH   (12),
        .AE_THRESH   (2)
    ) u_ct (
        .aclk           (aclk),
        .areset         (areset),
        .data_i         (d0_data),
        .last_i         (d0_last),
        .valid_i        (d0_valid),
        .ready_i        (r0_ready),
        .data_o         (q0_data),
        .last_o         (q0_last),
        .valid_o        (q0_valid),
        .ready_o        (d0_rdy),
        .count_o        (c0_count),
        .pkt_count_o    (c0_pkt),
        .almost_full_o  (f0_af),
        .almost_empty_o (f0_ae),
        .oversize_o     (o0_over)
    );

    axis_pkt_fifo #(
        .DATA_WIDTH  (9),
        .FIFO_DEPTH  (16),
        .PACKET_MODE (1),
        .AF_THRESH   (12),
        .AE_THRESH   (2)
    ) u_sf (
        .aclk           (aclk),
        .areset         (areset),
        .data_i         (d1_data),
        .last_i         (d1_last),
        .valid_i        (d1_valid),
        .ready_i        (r1_ready),
        .data_o         (q1_data),
        .last_o         (q1_last),
        .valid_o        (q1_valid),
        .ready_o        (d1_rdy),
        .count_o        (c1_count),
        .pkt_count_o    (c1_pkt),
        .almost_full_o  (f1_af),
        .almost_empty_o (f1_ae),
        .oversize_o     (o1_over)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int model_pkts();
        int n = 0;
        foreach (mq[i]) if (mq[i][9]) n++;
        return n;
    endfunction

    initial begin
        areset   = 1'b1;
        d0_data  = '0; d0_last = 1'b0; d0_valid = 1'b0; d0_rdy = 1'b0;
        d1_data  = '0; d1_last = 1'b0; d1_valid = 1'b0; d1_rdy = 1'b0;
        last_pat = 20'h93132;

        // Reset state
        tick();
        check("rst_ready_low", {31'd0, r0_ready}, 32'd0);
        check("rst_valid_low", {31'd0, q0_valid}, 32'd0);
        check("rst_count", {27'd0, c0_count}, 32'd0);
        areset = 1'b0;
        #1;
        check("rst_ready_high", {31'd0, r0_ready}, 32'd1);
        check("rst_af", {31'd0, f0_af}, 32'd0);
        check("rst_ae", {31'd0, f0_ae}, 32'd1);
        check("rst_pkt", {27'd0, c0_pkt}, 32'd0);
        check("rst_sf_valid", {31'd0, q1_valid}, 32'd0);
        check("rst_sf_over", {31'd0, o1_over}, 32'd0);

        // 1: fill cut-through FIFO, then drain in order
        for (int i = 0; i < 16; i++) begin
            d0_data = 9'(i); d0_valid = 1'b1;
            tick();
        end
        d0_data = 9'h055;
        check("t1_count16", {27'd0, c0_count}, 32'd16);
        check("t1_ready0", {31'd0, r0_ready}, 32'd0);
        check("t1_af", {31'd0, f0_af}, 32'd1);
        check("t1_ae", {31'd0, f0_ae}, 32'd0);
        tick();
        d0_valid = 1'b0;
        check("t1_nowrite_full", {27'd0, c0_count}, 32'd16);
        d0_rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("t1_data", {23'd0, q0_data}, 32'(i));
            if (i == 4)  check("t1_af_at12", {31'd0, f0_af}, 32'd1);
            if (i == 5)  check("t1_af_at11", {31'd0, f0_af}, 32'd0);
            if (i == 13) check("t1_ae_at3", {31'd0, f0_ae}, 32'd0);
            if (i == 14) check("t1_ae_at2", {31'd0, f0_ae}, 32'd1);
            tick();
        end
        d0_rdy = 1'b0;
        check("t1_count0", {27'd0, c0_count}, 32'd0);
        check("t1_ae_empty", {31'd0, f0_ae}, 32'd1);
        check("t1_valid0", {31'd0, q0_valid}, 32'd0);

        // 2: single word visible the cycle after it is written
        d0_data = 9'h1AA; d0_last = 1'b1; d0_valid = 1'b1;
        tick();
        d0_valid = 1'b0; d0_last = 1'b0;
        check("t2_valid", {31'd0, q0_valid}, 32'd1);
        check("t2_data", {23'd0, q0_data}, 32'h1AA);
        check("t2_last", {31'd0, q0_last}, 32'd1);
        check("t2_count", {27'd0, c0_count}, 32'd1);
        check("t2_pkt", {27'd0, c0_pkt}, 32'd1);
        d0_rdy = 1'b1;
        tick();
        d0_rdy = 1'b0;
        check("t2_count0", {27'd0, c0_count}, 32'd0);
        check("t2_pkt0", {27'd0, c0_pkt}, 32'd0);

        // 3: store-and-forward holds a packet back until its last beat
        for (int i = 0; i < 3; i++) begin
            d1_data = 9'h101 + 9'(i); d1_last = (i == 2); d1_valid = 1'b1;
            mq.push_back({d1_last, d1_data});
            tick();
            if (i < 2) check("t3_held", {31'd0, q1_valid}, 32'd0);
        end
        d1_valid = 1'b0; d1_last = 1'b0;
        check("t3_valid", {31'd0, q1_valid}, 32'd1);
        check("t3_pkt", {27'd0, c1_pkt}, 32'd1);
        check("t3_head", {23'd0, q1_data}, 32'h101);

        // 4: steady state at count 8 with simultaneous read and write
        for (int i = 0; i < 5; i++) begin
            d1_data = 9'h130 + 9'(i); d1_valid = 1'b1;
            mq.push_back({1'b0, d1_data});
            tick();
        end
        d1_valid = 1'b0;
        check("t4_count8", {27'd0, c1_count}, 32'd8);
        d1_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d1_data = 9'h140 + 9'(i); d1_last = last_pat[i]; d1_valid = 1'b1;
            #1;
            check("t4_head", {22'd0, q1_last, q1_data}, {22'd0, mq[0]});
            check("t4_count", {27'd0, c1_count}, 32'd8);
            check("t4_pkt", {27'd0, c1_pkt}, 32'(model_pkts()));
            void'(mq.pop_front());
            mq.push_back({d1_last, d1_data});
            tick();
        end
        d1_valid = 1'b0; d1_last = 1'b0;
        check("t4_pkt_end", {27'd0, c1_pkt}, 32'(model_pkts()));
        for (int i = 0; i < 20; i++) begin
            if (mq.size() == 0) break;
            check("t4_drain_valid", {31'd0, q1_valid}, 32'd1);
            check("t4_drain", {22'd0, q1_last, q1_data}, {22'd0, mq[0]});
            void'(mq.pop_front());
            tick();
        end
        d1_rdy = 1'b0;
        check("t4_empty", {27'd0, c1_count}, 32'd0);
        check("t4_pkt0", {27'd0, c1_pkt}, 32'd0);

        // 5: oversized packet escapes as cut-through
        for (int i = 0; i < 16; i++) begin
            d1_data = 9'h180 + 9'(i); d1_last = 1'b0; d1_valid = 1'b1;
            tick();
        end
        wr_idx  = 16;
        d1_data = 9'h190;
        check("t5_full", {27'd0, c1_count}, 32'd16);
        check("t5_ready0", {31'd0, r1_ready}, 32'd0);
        check("t5_af", {31'd0, f1_af}, 32'd1);
        check("t5_held", {31'd0, q1_valid}, 32'd0);
        check("t5_over_pre", {31'd0, o1_over}, 32'd0);
        tick();
        check("t5_over", {31'd0, o1_over}, 32'd1);
        check("t5_valid", {31'd0, q1_valid}, 32'd1);
        d1_rdy = 1'b1;
        rd_idx = 0;
        #1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (rd_idx == 20) break;
            do_rd = q1_valid;
            do_wr = d1_valid & r1_ready;
            if (do_rd) check("t5_beat", {22'd0, q1_last, q1_data},
                             {22'd0, (rd_idx == 19), 9'h180 + 9'(rd_idx)});
            tick();
            if (do_rd) rd_idx++;
            if (do_wr) wr_idx++;
            if (wr_idx < 20) begin
                d1_data = 9'h180 + 9'(wr_idx); d1_last = (wr_idx == 19); d1_valid = 1'b1;
            end else begin
                d1_valid = 1'b0; d1_last = 1'b0;
            end
            #1;
        end
        d1_rdy = 1'b0;
        check("t5_all_read", 32'(rd_idx), 32'd20);
        check("t5_over_sticky", {31'd0, o1_over}, 32'd1);
        check("t5_empty", {27'd0, c1_count}, 32'd0);
        // Back in normal mode a partial packet is held again
        for (int i = 0; i < 5; i++) begin
            d1_data = 9'h1B0 + 9'(i); d1_last = 1'b0; d1_valid = 1'b1;
            tick();
            check("t5_normal_held", {31'd0, q1_valid}, 32'd0);
        end
        d1_valid = 1'b0;
        check("t6_count5", {27'd0, c1_count}, 32'd5);

        // 6: reset mid-packet discards everything
        areset = 1'b1;
        tick();
        areset = 1'b0;
        #1;
        check("t6_count0", {27'd0, c1_count}, 32'd0);
        check("t6_valid0", {31'd0, q1_valid}, 32'd0);
        check("t6_ready1", {31'd0, r1_ready}, 32'd1);
        check("t6_over0", {31'd0, o1_over}, 32'd0);
        check("t6_ae", {31'd0, f1_ae}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            d1_data = 9'h1C0 + 9'(i); d1_last = (i == 3); d1_valid = 1'b1;
            tick();
        end
        d1_valid = 1'b0; d1_last = 1'b0;
        check("t6_valid", {31'd0, q1_valid}, 32'd1);
        check("t6_pkt", {27'd0, c1_pkt}, 32'd1);
        check("t6_count4", {27'd0, c1_count}, 32'd4);
        d1_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t6_beat", {22'd0, q1_last, q1_data}, {22'd0, (i == 3), 9'h1C0 + 9'(i)});
            tick();
        end
        d1_rdy = 1'b0;
        check("t6_end_count", {27'd0, c1_count}, 32'd0);
        check("t6_end_pkt", {27'd0, c1_pkt}, 32'd0);
        check("ct_never_oversize", {31'd0, o0_over}, 32'd0);
        check("ct_ae_idle", {31'd0, f0_ae}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
